// File: rtl/ledger_pkg.sv
// Shared definitions for the ledger write-back path: record layout,
// byte offsets inside the 48-bit record and the commit FSM encoding.
package ledger_pkg;

    // One ledger record is six bytes wide (48 bits).
    localparam int RECORD_BYTES = 6;
    localparam int RECORD_BITS  = RECORD_BYTES * 8;
    localparam int BYTE_IDX_W   = 3;

    // Byte offsets inside a record; byte 0 is the most significant byte.
    localparam logic [BYTE_IDX_W-1:0] OFF_P1_PRIV = 3'd0;
    localparam logic [BYTE_IDX_W-1:0] OFF_P1_PUB  = 3'd1;
    localparam logic [BYTE_IDX_W-1:0] OFF_P1_AMT  = 3'd2;
    localparam logic [BYTE_IDX_W-1:0] OFF_P2_PRIV = 3'd3;
    localparam logic [BYTE_IDX_W-1:0] OFF_P2_PUB  = 3'd4;
    localparam logic [BYTE_IDX_W-1:0] OFF_P2_AMT  = 3'd5;

    // Commit FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/ledger_byte_sel.sv
// Picks one byte out of a 48-bit ledger record by byte index.
// Index 0 is the MSB byte; out-of-range indices return zero.
module ledger_byte_sel
    import ledger_pkg::*;
(
    input  logic [RECORD_BITS-1:0] record,
    input  logic [BYTE_IDX_W-1:0]  idx,
    output logic [7:0]             rec_byte
);

    // Byte multiplexer over the six record fields.
    always_comb begin
        rec_byte = 8'h00;
        case (idx)
            OFF_P1_PRIV: rec_byte = record[47:40];
            OFF_P1_PUB:  rec_byte = record[39:32];
            OFF_P1_AMT:  rec_byte = record[31:24];
            OFF_P2_PRIV: rec_byte = record[23:16];
            OFF_P2_PUB:  rec_byte = record[15:8];
            OFF_P2_AMT:  rec_byte = record[7:0];
            default:     rec_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/ledger_writeback.sv
// Ledger write-back: commits a 48-bit record into the byte-wide ledger RAM
// as six consecutive byte writes, optionally reads the bytes back and flags
// any mismatch, then pulses done for one cycle.
//
// Handshake: start is sampled only in IDLE; a start seen while busy is
// dropped, not queued. busy is high in every non-IDLE state, done is a
// single-cycle pulse in DONE, and error (sticky until the next accepted
// start) is valid alongside done.
module ledger_writeback
    import ledger_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_BYTES  = RECORD_BYTES,
    parameter bit VERIFY     = 1'b1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [RECORD_BITS-1:0] result_in,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    output logic [ADDR_WIDTH-1:0]  ram_address,
    output logic [7:0]             ram_data,
    output logic                   ram_wren,
    input  logic [7:0]             ram_q,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output wb_state_t              dbg_state
);

    // Last write index, and the extra trailing compare-only cycle of VERIFY.
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX   = BYTE_IDX_W'(NUM_BYTES - 1);
    localparam logic [BYTE_IDX_W-1:0] VERIFY_END = BYTE_IDX_W'(NUM_BYTES);

    wb_state_t               state_q, state_d;
    logic [BYTE_IDX_W-1:0]   idx_q, idx_d;
    logic [RECORD_BITS-1:0]  rec_q, rec_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic                    error_q, error_d;

    logic [BYTE_IDX_W-1:0]   sel_idx;
    logic [7:0]              sel_byte;

    // Byte index for the shared mux: the current write index, or in VERIFY
    // the index whose read data is arriving this cycle (one behind).
    always_comb begin
        sel_idx = idx_q;
        if (state_q == ST_VERIFY && idx_q != '0) begin
            sel_idx = idx_q - 3'd1;
        end
    end

    ledger_byte_sel u_byte_sel (
        .record   (rec_q),
        .idx      (sel_idx),
        .rec_byte (sel_byte)
    );

    // Next-state and RAM port logic for the commit FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rec_d       = rec_q;
        base_d      = base_q;
        error_d     = error_q;
        ram_wren    = 1'b0;
        ram_address = '0;
        ram_data    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rec_d   = result_in;
                    base_d  = base_addr;
                    error_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                ram_wren    = 1'b1;
                // Address wraps modulo 2^ADDR_WIDTH.
                ram_address = base_q + ADDR_WIDTH'(idx_q);
                ram_data    = sel_byte;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = VERIFY ? ST_VERIFY : ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end

            ST_VERIFY: begin
                // Present address k while comparing the read data of k-1.
                if (idx_q != VERIFY_END) begin
                    ram_address = base_q + ADDR_WIDTH'(idx_q);
                end
                if (idx_q != '0 && ram_q != sel_byte) begin
                    error_d = 1'b1;
                end
                if (idx_q == VERIFY_END) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and snapshot registers; reset aborts any commit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rec_q   <= '0;
            base_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rec_q   <= rec_d;
            base_q  <= base_d;
            error_q <= error_d;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        error     = error_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_ledger_writeback.sv
// Directed bench for ledger_writeback: one instance with read-back verify
// and one without, each talking to its own byte-wide RAM model.
module tb_ledger_writeback;
    import ledger_pkg::*;

    // Clock and reset
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    // Shared stimulus
    logic [47:0] result_in = '0;
    logic [4:0]  base_addr = '0;
    logic        start_v   = 1'b0;
    logic        start_n   = 1'b0;

    // Verify-enabled instance
    logic [4:0]  addr_v;
    logic [7:0]  data_v, q_v;
    logic        wren_v, busy_v, done_v, err_v;
    wb_state_t   dbg_v;

    // Verify-disabled instance
    logic [4:0]  addr_n;
    logic [7:0]  data_n, q_n;
    logic        wren_n, busy_n, done_n, err_n;
    wb_state_t   dbg_n;

    // RAM models
    logic [7:0]  mem_v [32];
    logic [7:0]  mem_n [32];
    logic        corrupt_en   = 1'b0;
    logic [4:0]  corrupt_addr = 5'd7;
    int          wr_cnt_v = 0;
    int          wr_cnt_n = 0;

    // Scoreboard
    logic [12:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    ledger_writeback #(.ADDR_WIDTH(5), .NUM_BYTES(6), .VERIFY(1'b1)) dut_v (
        .clock(clock), .resetn(resetn), .start(start_v), .result_in(result_in),
        .base_addr(base_addr), .ram_address(addr_v), .ram_data(data_v),
        .ram_wren(wren_v), .ram_q(q_v), .busy(busy_v), .done(done_v),
        .error(err_v), .dbg_state(dbg_v)
    );

    ledger_writeback #(.ADDR_WIDTH(5), .NUM_BYTES(6), .VERIFY(1'b0)) dut_n (
        .clock(clock), .resetn(resetn), .start(start_n), .result_in(result_in),
        .base_addr(base_addr), .ram_address(addr_n), .ram_data(data_n),
        .ram_wren(wren_n), .ram_q(q_n), .busy(busy_n), .done(done_n),
        .error(err_n), .dbg_state(dbg_n)
    );

    // Synchronous-read RAM, optional read corruption on one address
    always @(posedge clock) begin
        if (wren_v) begin
            mem_v[addr_v] <= data_v;
            wr_cnt_v      <= wr_cnt_v + 1;
        end
        q_v <= (corrupt_en && addr_v == corrupt_addr) ? 8'h00 : mem_v[addr_v];
    end

    always @(posedge clock) begin
        if (wren_n) begin
            mem_n[addr_n] <= data_n;
            wr_cnt_n      <= wr_cnt_n + 1;
        end
        q_n <= mem_n[addr_n];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Commit on the verify instance; E0 is the edge that samples start.
    task automatic commit_v(input logic [4:0] base, input logic [47:0] rec,
                            input logic exp_err, input logic mid_start);
        logic [12:0] e;
        result_in = rec;
        base_addr = base;
        start_v   = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            if (c == 0) begin
                start_v   = 1'b0;
                result_in = ~rec;
                base_addr = base + 5'd3;
                check("err_clear_on_start", err_v, 1'b0);
            end
            if (mid_start) start_v = (c == 2);
            check("busy_v", busy_v, 1'b1);
            check("done_v_timing", done_v, c == 13);
            if (c < 6) begin
                e = exp_q.pop_front();
                check("wren_v_write", wren_v, 1'b1);
                check("wr_addr_v", addr_v, e[12:8]);
                check("wr_data_v", data_v, e[7:0]);
            end else begin
                check("wren_v_verify", wren_v, 1'b0);
                if (c < 12) check("rd_addr_v", addr_v, base + 5'(c - 6));
            end
            if (c == 13) check("err_at_done", err_v, exp_err);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("busy_v_after", busy_v, 1'b0);
            check("done_v_after", done_v, 1'b0);
            check("err_v_hold", err_v, exp_err);
        end
    endtask

    // Commit on the non-verify instance: done directly after the last write.
    task automatic commit_n(input logic [4:0] base, input logic [47:0] rec);
        logic [12:0] e;
        result_in = rec;
        base_addr = base;
        start_n   = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            if (c == 0) start_n = 1'b0;
            check("busy_n", busy_n, 1'b1);
            check("done_n_timing", done_n, c == 6);
            if (c < 6) begin
                e = exp_q.pop_front();
                check("wren_n_write", wren_n, 1'b1);
                check("wr_addr_n", addr_n, e[12:8]);
                check("wr_data_n", data_n, e[7:0]);
            end else begin
                check("wren_n_done", wren_n, 1'b0);
                check("addr_n_done", addr_n, 5'd0);
            end
        end
        @(negedge clock);
        check("busy_n_after", busy_n, 1'b0);
        check("err_n", err_n, 1'b0);
    endtask

    initial begin
        int n0;
        logic [12:0] e;
        logic [7:0] hb [6];

        // Reset, then ten idle cycles
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("idle_wren", wren_v, 1'b0);
            check("idle_busy", busy_v, 1'b0);
            check("idle_done", done_v, 1'b0);
            check("idle_error", err_v, 1'b0);
            check("idle_addr", addr_v, 5'd0);
            check("idle_data", data_v, 8'd0);
            check("idle_state", dbg_v, ST_IDLE);
            check("idle_wren_n", wren_n, 1'b0);
        end

        // Basic commit with read-back
        exp_q.push_back({5'd4, 8'h0A}); exp_q.push_back({5'd5, 8'h1B});
        exp_q.push_back({5'd6, 8'h2C}); exp_q.push_back({5'd7, 8'h3D});
        exp_q.push_back({5'd8, 8'h4E}); exp_q.push_back({5'd9, 8'h5F});
        commit_v(5'd4, 48'h0A1B2C3D4E5F, 1'b0, 1'b0);
        check("mem_v_4", mem_v[4], 8'h0A);
        check("mem_v_9", mem_v[9], 8'h5F);

        // Mismatch: read-back of address 7 corrupted
        corrupt_en = 1'b1;
        exp_q.push_back({5'd4, 8'h0A}); exp_q.push_back({5'd5, 8'h1B});
        exp_q.push_back({5'd6, 8'h2C}); exp_q.push_back({5'd7, 8'h3D});
        exp_q.push_back({5'd8, 8'h4E}); exp_q.push_back({5'd9, 8'h5F});
        commit_v(5'd4, 48'h0A1B2C3D4E5F, 1'b1, 1'b0);
        corrupt_en = 1'b0;

        // Start while busy (also clears the sticky error)
        n0 = wr_cnt_v;
        exp_q.push_back({5'd10, 8'h11}); exp_q.push_back({5'd11, 8'h22});
        exp_q.push_back({5'd12, 8'h33}); exp_q.push_back({5'd13, 8'h44});
        exp_q.push_back({5'd14, 8'h55}); exp_q.push_back({5'd15, 8'h66});
        commit_v(5'd10, 48'h112233445566, 1'b0, 1'b1);
        check("busy_start_writes", wr_cnt_v - n0, 6);

        // Address wrap, no read-back
        n0 = wr_cnt_n;
        exp_q.push_back({5'd30, 8'hFF}); exp_q.push_back({5'd31, 8'hEE});
        exp_q.push_back({5'd0, 8'hDD});  exp_q.push_back({5'd1, 8'hCC});
        exp_q.push_back({5'd2, 8'hBB});  exp_q.push_back({5'd3, 8'hAA});
        commit_n(5'd30, 48'hFFEEDDCCBBAA);
        check("wrap_write_count", wr_cnt_n - n0, 6);
        check("mem_n_31", mem_n[31], 8'hEE);
        check("mem_n_0", mem_n[0], 8'hDD);

        // start held high: second commit begins one idle cycle after done
        hb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 6; i++) exp_q.push_back({5'(i), hb[i]});
        result_in = 48'h010203040506;
        base_addr = 5'd0;
        start_n   = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if (c == 8) start_n = 1'b0;
            check("held_wren", wren_n, (c < 6) || (c >= 8 && c < 14));
            check("held_done", done_n, (c == 6) || (c == 14));
            check("held_busy", busy_n, !((c == 7) || (c == 15)));
            if ((c < 6) || (c >= 8 && c < 14)) begin
                e = exp_q.pop_front();
                check("held_addr", addr_n, e[12:8]);
                check("held_data", data_n, e[7:0]);
            end
        end

        // Reset in the middle of the write phase
        exp_q.delete();
        result_in = 48'h0A1B2C3D4E5F;
        base_addr = 5'd20;
        n0        = wr_cnt_v;
        start_v   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start_v = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("rst_wren_drop", wren_v, 1'b0);
        check("rst_busy_drop", busy_v, 1'b0);
        check("rst_addr", addr_v, 5'd0);
        check("rst_state", dbg_v, ST_IDLE);
        check("rst_bytes_written", wr_cnt_v - n0, 2);
        @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            check("post_rst_wren", wren_v, 1'b0);
            check("post_rst_busy", busy_v, 1'b0);
        end
        check("post_rst_no_writes", wr_cnt_v - n0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ledger_writeback.md
Name: ledger_writeback

Overview:
- Commits a finished 48-bit ledger record back into the byte-wide player ledger RAM. This is the write path; the transaction datapath is the read path that consumes the same record.
- Serialises the record into six byte writes, then optionally reads the bytes back and compares them.
- Reports completion or mismatch to the top-level control FSM with a start/done handshake.

Parameters:
- ADDR_WIDTH, 5, width of the ledger RAM address.
- NUM_BYTES, 6, number of bytes in one record (fixed by the 48-bit layout).
- VERIFY, 1, 1 = run the read-back compare phase; 0 = skip it.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request a commit; sampled only in IDLE.
- result_in  in  48  record to commit: {p1_private, p1_public, p1_amount, p2_private, p2_public, p2_amount}, 8 bits each, MSB first.
- base_addr  in  ADDR_WIDTH  RAM address of record byte 0.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_data  out  8  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  8  RAM read data; valid one cycle after ram_address is presented.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  read-back mismatch flag (sticky).

Behaviour:
- Reset, asynchronous, effective immediately:
  - state = IDLE; all counters and snapshot registers = 0.
  - ram_wren = 0, ram_address = 0, ram_data = 0, busy = 0, done = 0, error = 0.
  - A reset mid-write aborts the commit. Bytes already written stay in RAM. No further write is issued.
- States: IDLE, WRITE, VERIFY, DONE. Encoding is in the shared package.
- IDLE:
  - Outputs quiescent (wren = 0, address = 0, data = 0).
  - start = 1 at an edge: snapshot result_in and base_addr, clear error, idx = 0, go to WRITE.
- WRITE, one byte per cycle, idx = 0..5:
  - ram_wren = 1, ram_address = base + idx, ram_data = byte[idx].
  - Byte order: byte0 = result_in[47:40], byte1 = [39:32], ..., byte5 = [7:0].
  - When idx = NUM_BYTES-1: go to VERIFY if VERIFY = 1, else go to DONE.
- VERIFY, NUM_BYTES+1 cycles, ram_wren = 0:
  - Cycle k (k < NUM_BYTES) drives ram_address = base + k.
  - Cycle k+1 compares ram_q against byte[k].
  - Any mismatch sets error. Error is sticky; later bytes are still checked.
  - Final cycle performs only the compare for byte 5, then goes to DONE.
- DONE: done = 1 for exactly one cycle, busy = 1, then IDLE.
- Address arithmetic: base + idx is computed modulo 2^ADDR_WIDTH, so it wraps. Example: base = 31 writes addresses 31, 0, 1, 2, 3, 4.
- Latency, counting edge E0 as the edge that samples start:
  - done is high in the cycle E13–E14 when VERIFY = 1.
  - done is high in the cycle E6–E7 when VERIFY = 0.
  - busy is high from E0 until done falls.
- start while busy is ignored and not queued.
- start held high continuously: a new commit begins at the first edge back in IDLE, one cycle after done.
- Changes to result_in or base_addr after E0 have no effect on the commit in progress; the snapshot is used throughout.
- error holds until the next accepted start or reset. It is valid alongside done.

Decomposition:
- Shared package (ledger_pkg):
  - RECORD_BYTES = 6.
  - Byte-offset constants: OFF_P1_PRIV = 0, OFF_P1_PUB = 1, OFF_P1_AMT = 2, OFF_P2_PRIV = 3, OFF_P2_PUB = 4, OFF_P2_AMT = 5.
  - State encoding for IDLE/WRITE/VERIFY/DONE.
- One sub-module, ledger_byte_sel: combinational mux, 48-bit record plus 3-bit index to 8-bit byte. It is shared by the write path and the compare path.

Test Plan:
- Reset then idle: start = 0 for 10 cycles → wren, busy, done, error all 0; address = 0.
- Basic commit, VERIFY = 1, base = 4, result_in = 0x0A1B2C3D4E5F:
  - Writes 0x0A→4, 0x1B→5, 0x2C→6, 0x3D→7, 0x4E→8, 0x5F→9 on consecutive cycles.
  - RAM model echoes the data → done pulses at E13, error = 0.
- Mismatch: as above, but the RAM model corrupts address 7 to 0x00 → error = 1 with done at E13. error stays 1 in IDLE and clears on the next start.
- Wrap and VERIFY = 0: base = 30, record 0xFFEEDDCCBBAA → addresses 30, 31, 0, 1, 2, 3; done at E6; no read cycles occur.
- start while busy: pulse start at E3 with different result_in → ignored; the original record is written; exactly one done.
- Reset mid-WRITE: assert resetn = 0 after the second byte → wren drops immediately. After release, the block is in IDLE and no further RAM writes occur.
